uart_tx: RTL and testbench

//  UART transmitter; the transmit-side counterpart of the UART receive FSM. Accepts one byte via

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART constants and state encodings, common to the transmit and
// receive FSMs.
//   WIDTH_DATABITS      data bits per frame
//   WIDTH_DATABITS_SIZE width of a counter that indexes the data bits
//   WIDTH_UART_STATES   width of the UART FSM state register
//   IDLE_BITS           guard idle bits driven high after the last stop bit
package uart_tx_pkg;

  localparam int WIDTH_DATABITS      = 8;
  localparam int WIDTH_DATABITS_SIZE = $clog2(WIDTH_DATABITS);
  localparam int WIDTH_UART_STATES   = 3;
  localparam int IDLE_BITS           = 2;
  // Guard counter must reach IDLE_BITS, one past the last guard index.
  localparam int WIDTH_GUARD         = $clog2(IDLE_BITS + 1);

  typedef enum logic [WIDTH_UART_STATES-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GUARD  = 3'd5
  } uart_state_e;

  // Even parity: XOR of all data bits.
  function automatic logic even_parity(input logic [WIDTH_DATABITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter. Accepts one byte over valid/ready and serialises it MSB
// first: START, data bits, optional even PARITY, one or two STOP bits, then
// IDLE_BITS guard bits at idle level. Bit timing comes from the external
// one-cycle strobe 'tick'; every tick starts the next bit.
// Ports:
//   clk        system clock, posedge
//   rst        synchronous reset, active-high
//   tick       bit-period strobe
//   paritybit  1 = append even parity bit
//   stopbit    0 = one stop bit, 1 = two stop bits
//   in         byte to send
//   valid_in   byte on 'in' is valid
//   ready_in   block can accept a byte (IDLE only)
//   tx         registered serial line, idle high
//   busy       frame in progress
//   done       one-cycle pulse when frame and guard bits are complete
module uart_tx
  import uart_tx_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      paritybit,
  input  logic                      stopbit,
  input  logic [WIDTH_DATABITS-1:0] in,
  input  logic                      valid_in,
  output logic                      ready_in,
  output logic                      tx,
  output logic                      busy,
  output logic                      done
);

  uart_state_e                    state_q, state_d;
  logic [WIDTH_DATABITS-1:0]      shift_q, shift_d;
  logic [WIDTH_DATABITS_SIZE-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH_GUARD-1:0]         guard_cnt_q, guard_cnt_d;
  logic                           stop_cnt_q, stop_cnt_d;
  logic                           par_en_q, par_en_d;
  logic                           par_val_q, par_val_d;
  logic                           stop2_q, stop2_d;
  logic                           tx_q, tx_d;
  logic                           done_q, done_d;

  assign ready_in = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign tx       = tx_q;
  assign done     = done_q;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    guard_cnt_d = guard_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    par_en_d    = par_en_q;
    par_val_d   = par_val_q;
    stop2_d     = stop2_q;
    tx_d        = tx_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // Acceptance ignores tick: the start bit waits for the next strobe.
        if (valid_in) begin
          shift_d     = in;
          par_en_d    = paritybit;
          par_val_d   = even_parity(in);
          stop2_d     = stopbit;
          bit_cnt_d   = '0;
          guard_cnt_d = '0;
          stop_cnt_d  = 1'b0;
          state_d     = ST_START;
        end
      end
      ST_START: if (tick) begin
        tx_d    = 1'b0;
        state_d = ST_DATA;
      end
      ST_DATA: if (tick) begin
        tx_d      = shift_q[WIDTH_DATABITS-1];
        shift_d   = {shift_q[WIDTH_DATABITS-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        // The tick that drives the last data bit picks the next field.
        if (bit_cnt_q == WIDTH_DATABITS_SIZE'(WIDTH_DATABITS - 1)) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (tick) begin
        tx_d    = par_val_q;
        state_d = ST_STOP;
      end
      ST_STOP: if (tick) begin
        tx_d = 1'b1;
        if (stop2_q && !stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else begin
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: if (tick) begin
        tx_d = 1'b1;
        // First tick here ends the stop bit; IDLE_BITS more ticks span the
        // guard bits, and the last of them ends the frame.
        if (guard_cnt_q == WIDTH_GUARD'(IDLE_BITS)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      guard_cnt_q <= '0;
      stop_cnt_q  <= 1'b0;
      par_en_q    <= 1'b0;
      par_val_q   <= 1'b0;
      stop2_q     <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      par_en_q    <= par_en_d;
      par_val_q   <= par_val_d;
      stop2_q     <= stop2_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx. Inputs change on the falling edge, outputs
// are sampled on the falling edge. Expected line levels come from a small
// frame model built from the byte and configuration.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       paritybit;
  logic       stopbit;
  logic [7:0] din;
  logic       valid_in;
  logic       ready_in;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  uart_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .paritybit (paritybit),
    .stopbit   (stopbit),
    .in        (din),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level for bit periods 1..n (bit k is driven by the k-th tick after
  // acceptance); the tick numbered n+1 ends the last guard bit.
  task automatic build_frame(input logic [7:0] d, input logic p, input logic s,
                             output logic [15:0] bits, output int n);
    int idx;
    bits    = '1;
    bits[1] = 1'b0;
    for (int i = 0; i < 8; i++) bits[2 + i] = d[7 - i];
    idx = 10;
    if (p) begin bits[idx] = ^d; idx++; end
    bits[idx] = 1'b1; idx++;
    if (s) begin bits[idx] = 1'b1; idx++; end
    bits[idx] = 1'b1; idx++;
    bits[idx] = 1'b1; idx++;
    n = idx - 1;
  endtask

  task automatic post_accept(input string tag);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready"}, ready_in, 0);
    check({tag, "_tx_idle"}, tx, 1);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic accept(input logic [7:0] d, input logic p, input logic s, input logic tick_same);
    @(negedge clk);
    check("accept_ready", ready_in, 1);
    din       = d;
    paritybit = p;
    stopbit   = s;
    valid_in  = 1'b1;
    tick      = tick_same;
    @(negedge clk);
    valid_in = 1'b0;
    tick     = 1'b0;
    post_accept("post_accept");
  endtask

  // Ticks through a frame with 'period' cycles per bit. 'hold' keeps valid_in
  // high with another byte throughout; 'toggle' flips the config inputs
  // mid-frame. Ends at the falling edge of the done cycle.
  task automatic observe(input logic [7:0] d, input logic p, input logic s, input int period,
                         input logic hold, input logic [7:0] hold_d, input logic toggle);
    logic [15:0] bits;
    int          n;
    build_frame(d, p, s, bits, n);
    if (hold) begin
      valid_in = 1'b1;
      din      = hold_d;
    end
    for (int k = 1; k <= n + 1; k++) begin
      if (toggle && k == 5) begin
        paritybit = ~paritybit;
        stopbit   = ~stopbit;
        din       = ~din;
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (k <= n) begin
        check($sformatf("tx_bit%0d", k), tx, bits[k]);
        check($sformatf("no_done_bit%0d", k), done, 0);
        if (hold) check($sformatf("held_valid_unaccepted%0d", k), ready_in, 0);
        for (int c = 1; c < period; c++) begin
          @(negedge clk);
          check($sformatf("tx_hold_bit%0d", k), tx, bits[k]);
          check($sformatf("busy_bit%0d", k), busy, 1);
        end
      end else begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_ready", ready_in, 1);
        check("done_tx", tx, 1);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    tick      = 1'b0;
    paritybit = 1'b0;
    stopbit   = 1'b0;
    din       = 8'h00;
    valid_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_ready", ready_in, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    // Tick every cycle, no parity, one stop bit: done on tick 13.
    accept(8'hA5, 1'b0, 1'b0, 1'b0);
    observe(8'hA5, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0);

    // Parity and two stop bits: 00000111, parity 1.
    accept(8'h07, 1'b1, 1'b1, 1'b0);
    observe(8'h07, 1'b1, 1'b1, 1, 1'b0, 8'h00, 1'b0);

    // Tick every 16 cycles while the next byte waits on valid_in; it is
    // accepted only at the edge that ends the done cycle.
    accept(8'h3C, 1'b0, 1'b1, 1'b0);
    paritybit = 1'b1;
    stopbit   = 1'b0;
    observe(8'h3C, 1'b0, 1'b1, 16, 1'b1, 8'hC3, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    post_accept("back_to_back");
    observe(8'hC3, 1'b1, 1'b0, 2, 1'b0, 8'h00, 1'b0);

    // Tick coincident with acceptance is ignored.
    accept(8'h5A, 1'b1, 1'b0, 1'b1);
    observe(8'h5A, 1'b1, 1'b0, 3, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of the data bits: 0x96 -> after tick 6 tx = d[3] = 0.
    accept(8'h96, 1'b0, 1'b0, 1'b0);
    tick = 1'b1;
    repeat (6) @(negedge clk);
    tick = 1'b0;
    check("abort_pre_tx", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", tx, 1);
    check("abort_ready", ready_in, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_no_done", done, 0);
    accept(8'hE1, 1'b0, 1'b0, 1'b0);
    observe(8'hE1, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0);

    // Config and data toggled mid-frame; the next frame uses the new config.
    accept(8'h81, 1'b0, 1'b0, 1'b0);
    observe(8'h81, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b1);
    accept(8'h81, paritybit, stopbit, 1'b0);
    observe(8'h81, 1'b1, 1'b1, 1, 1'b0, 8'h00, 1'b0);

    // Tick held low freezes the idle line.
    repeat (5) @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
